// File: rtl/register_file_mp.sv
// Multi-port integer register file with combinational read ports, two
// writeback ports, optional write-to-read bypass and a busy scoreboard.

module register_file_mp_rd #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int BYPASS   = 1
) (
  input  logic                             live,
  input  logic [ADDR_W-1:0]                addr,
  input  logic [NUM_REGS-1:0][DATA_W-1:0]  regs,
  input  logic [NUM_REGS-1:0]              busy,
  input  logic                             wr0_ok,
  input  logic [ADDR_W-1:0]                wr0_addr,
  input  logic [DATA_W-1:0]                wr0_data,
  input  logic                             wr1_ok,
  input  logic [ADDR_W-1:0]                wr1_addr,
  input  logic [DATA_W-1:0]                wr1_data,
  output logic [DATA_W-1:0]                rd_data,
  output logic                             rd_busy
);
  logic in_range;
  assign in_range = ({1'b0, addr} < (ADDR_W+1)'(NUM_REGS));

  always_comb begin
    rd_data = '0;
    rd_busy = 1'b0;
    if (live && in_range) begin
      rd_data = regs[addr];
      rd_busy = busy[addr];
      // A write landing this cycle both supplies the data and retires the producer.
      if (BYPASS != 0) begin
        if (wr1_ok && wr1_addr == addr) begin
          rd_data = wr1_data;
          rd_busy = 1'b0;
        end else if (wr0_ok && wr0_addr == addr) begin
          rd_data = wr0_data;
          rd_busy = 1'b0;
        end
      end
    end
  end
endmodule

module register_file_mp #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = $clog2(NUM_REGS),
  parameter int NUM_RD   = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_RD*ADDR_W-1:0] rs_addr,
  output logic [NUM_RD*DATA_W-1:0] rs_data,
  output logic [NUM_RD-1:0]        rs_busy,
  input  logic                     wr0_en,
  input  logic [ADDR_W-1:0]        wr0_addr,
  input  logic [DATA_W-1:0]        wr0_data,
  input  logic                     wr1_en,
  input  logic [ADDR_W-1:0]        wr1_addr,
  input  logic [DATA_W-1:0]        wr1_data,
  input  logic                     iss_en,
  input  logic [ADDR_W-1:0]        iss_addr,
  input  logic                     flush,
  output logic [ADDR_W:0]          busy_cnt
);
  localparam int CW = ADDR_W + 1;

  logic [NUM_REGS-1:0][DATA_W-1:0] regs;
  logic [NUM_REGS-1:0]             busy, busy_nxt;
  logic [CW-1:0]                   cnt_nxt;
  logic                            wr0_ok, wr1_ok, iss_ok;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < CW'(NUM_REGS)) && !(ZERO_REG != 0 && a == '0);
  endfunction

  assign wr0_ok = wr0_en && addr_ok(wr0_addr);
  assign wr1_ok = wr1_en && addr_ok(wr1_addr);
  assign iss_ok = iss_en && addr_ok(iss_addr);

  // wr1 is applied last so it wins a same-address collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regs <= '0;
    end else begin
      if (wr0_ok) regs[wr0_addr] <= wr0_data;
      if (wr1_ok) regs[wr1_addr] <= wr1_data;
    end
  end

  // Later assignments carry higher priority: flush > issue > writeback clear.
  always_comb begin
    busy_nxt = busy;
    if (wr0_ok) busy_nxt[wr0_addr] = 1'b0;
    if (wr1_ok) busy_nxt[wr1_addr] = 1'b0;
    if (iss_ok) busy_nxt[iss_addr] = 1'b1;
    if (flush)  busy_nxt = '0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NUM_REGS; i++) cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_nxt;
      busy_cnt <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    register_file_mp_rd #(
      .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .BYPASS(BYPASS)
    ) u_rd (
      .live     (rst_n),
      .addr     (rs_addr[k*ADDR_W +: ADDR_W]),
      .regs     (regs),
      .busy     (busy),
      .wr0_ok   (wr0_ok),
      .wr0_addr (wr0_addr),
      .wr0_data (wr0_data),
      .wr1_ok   (wr1_ok),
      .wr1_addr (wr1_addr),
      .wr1_data (wr1_data),
      .rd_data  (rs_data[k*DATA_W +: DATA_W]),
      .rd_busy  (rs_busy[k])
    );
  end
endmodule
